// File: rtl/conv_n_m.sv
// conv_n_m: streaming 1-D valid convolution of an N-sample x vector with an
// M-tap filter f, producing N-M+1 signed outputs per loaded vector pair.
// Single multiply-accumulate datapath, one product per cycle.
module conv_n_m #(
  parameter  int N    = 8,
  parameter  int M    = 4,
  parameter  int T    = 8,
  parameter  int RELU = 0,
  localparam int OW   = 2*T + $clog2(M)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [T-1:0]         s_data_in_x,
  input  logic                 s_valid_x,
  output logic                 s_ready_x,
  input  logic [T-1:0]         s_data_in_f,
  input  logic                 s_valid_f,
  output logic                 s_ready_f,
  output logic signed [OW-1:0] m_data_out_y,
  output logic                 m_valid_y,
  input  logic                 m_ready_y
);

  localparam int CW = $clog2(N+1);
  localparam int XA = $clog2(N);
  localparam int FA = $clog2(M);

  localparam logic [CW-1:0] X_FULL   = CW'(N);
  localparam logic [CW-1:0] F_FULL   = CW'(M);
  localparam logic [CW-1:0] MAC_LAST = CW'(M);
  localparam logic [XA-1:0] K_LAST   = XA'(N-M);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]           state;
  logic [CW-1:0]        x_cnt;
  logic [CW-1:0]        f_cnt;
  logic [CW-1:0]        mac_cnt;
  logic [XA-1:0]        k;
  logic signed [OW-1:0] acc;
  logic signed [OW-1:0] y_r;
  logic                 valid_r;

  logic [T-1:0]         x_buf [N];
  logic [T-1:0]         f_buf [M];
  logic [T-1:0]         x_rd;
  logic [T-1:0]         f_rd;

  logic                 x_fire;
  logic                 f_fire;
  logic [XA-1:0]        x_addr;
  logic [FA-1:0]        f_addr;
  logic [2*T-1:0]       prod;
  logic signed [OW-1:0] acc_sum;
  logic signed [OW-1:0] y_next;

  // Handshake decode from state and counts only; reset forces everything quiet.
  always_comb begin
    s_ready_x    = !reset && (state == S_LOAD) && (x_cnt != X_FULL);
    s_ready_f    = !reset && (state == S_LOAD) && (f_cnt != F_FULL);
    m_valid_y    = !reset && valid_r;
    m_data_out_y = reset ? '0 : y_r;
    x_fire       = s_valid_x && s_ready_x;
    f_fire       = s_valid_f && s_ready_f;
  end

  // Read addresses, product and accumulation/clamp arithmetic.
  always_comb begin
    x_addr  = k + XA'(mac_cnt);
    f_addr  = FA'(mac_cnt);
    prod    = {{T{x_rd[T-1]}}, x_rd} * {{T{f_rd[T-1]}}, f_rd};
    acc_sum = acc + {{(OW-2*T){prod[2*T-1]}}, prod};
    y_next  = acc_sum;
    if ((RELU != 0) && acc_sum[OW-1]) begin
      y_next = '0;
    end
  end

  // Sample buffers, written in arrival order; contents are never reset.
  always_ff @(posedge clk) begin
    if (x_fire) begin
      x_buf[x_cnt[XA-1:0]] <= s_data_in_x;
    end
    if (f_fire) begin
      f_buf[f_cnt[FA-1:0]] <= s_data_in_f;
    end
  end

  // Registered buffer reads: data for step j arrives one cycle after issue.
  always_ff @(posedge clk) begin
    x_rd <= x_buf[x_addr];
    f_rd <= f_buf[f_addr];
  end

  // Control FSM and MAC: reads issued at mac_cnt 0..M-1, products summed at
  // mac_cnt 1..M; the final sum is folded straight into the output register
  // on the last step so the result is valid M+1 cycles after entering S_MAC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_LOAD;
      x_cnt   <= '0;
      f_cnt   <= '0;
      mac_cnt <= '0;
      k       <= '0;
      acc     <= '0;
      y_r     <= '0;
      valid_r <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (x_fire) begin
            x_cnt <= x_cnt + 1'b1;
          end
          if (f_fire) begin
            f_cnt <= f_cnt + 1'b1;
          end
          if ((x_cnt == X_FULL) && (f_cnt == F_FULL)) begin
            state   <= S_MAC;
            k       <= '0;
            mac_cnt <= '0;
            acc     <= '0;
          end
        end
        S_MAC: begin
          mac_cnt <= mac_cnt + 1'b1;
          if (mac_cnt == '0) begin
            acc <= '0;
          end else begin
            acc <= acc_sum;
          end
          if (mac_cnt == MAC_LAST) begin
            y_r     <= y_next;
            valid_r <= 1'b1;
            state   <= S_OUT;
          end
        end
        S_OUT: begin
          if (m_ready_y) begin
            valid_r <= 1'b0;
            mac_cnt <= '0;
            if (k == K_LAST) begin
              state <= S_LOAD;
              x_cnt <= '0;
              f_cnt <= '0;
              k     <= '0;
            end else begin
              k     <= k + 1'b1;
              state <= S_MAC;
            end
          end
        end
        default: begin
          state <= S_LOAD;
        end
      endcase
    end
  end

endmodule
